// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO responder.
package mdio_pkg;

    typedef enum logic [2:0] {
        PRE,
        ST,
        OP,
        PHYAD,
        REGAD,
        TA,
        DATA,
        SKIP
    } mdio_state_e;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;

    localparam int SKIP_AFTER_PHYAD = 18;
    localparam int SKIP_AFTER_TA    = 16;

endpackage

// File: rtl/mdio_sync.sv
// Brings MDC and MDIO into the system clock domain and flags MDC rising edges.
module mdio_sync (
    input  logic clock,
    input  logic rst_n,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdio_s
);

    logic mdc_meta_q, mdc_sync_q, mdc_prev_q;
    logic mdio_meta_q, mdio_sync_q;

    // Idle-high reset values avoid a false edge if MDC is already high at reset release.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mdc_meta_q  <= 1'b1;
            mdc_sync_q  <= 1'b1;
            mdc_prev_q  <= 1'b1;
            mdio_meta_q <= 1'b1;
            mdio_sync_q <= 1'b1;
        end else begin
            mdc_meta_q  <= mdc;
            mdc_sync_q  <= mdc_meta_q;
            mdc_prev_q  <= mdc_sync_q;
            mdio_meta_q <= mdio_i;
            mdio_sync_q <= mdio_meta_q;
        end
    end

    assign mdc_rise = mdc_sync_q & ~mdc_prev_q;
    assign mdio_s   = mdio_sync_q;

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder: decodes frames on oversampled MDC rises,
// commits writes to a register port and serves reads back onto MDIO.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         PRE_LEN  = 32
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic        reg_re,
    input  logic [15:0] reg_rdata,
    output logic        reg_we,
    output logic [15:0] reg_wdata,
    output logic        frame_err
);

    localparam int               PRE_W      = $clog2(PRE_LEN + 1);
    localparam logic [PRE_W-1:0] PRE_SAT    = PRE_W'(PRE_LEN);
    localparam logic [4:0]       PHYAD_LAST = 5'(PHYAD_W - 1);
    localparam logic [4:0]       REGAD_LAST = 5'(REGAD_W - 1);
    localparam logic [4:0]       DATA_LAST  = 5'(DATA_W - 1);
    localparam logic [4:0]       SKIP_PHY   = 5'(SKIP_AFTER_PHYAD);
    localparam logic [4:0]       SKIP_TAE   = 5'(SKIP_AFTER_TA);

    logic mdc_rise;
    logic mdio_s;

    mdio_sync u_sync (
        .clock    (clock),
        .rst_n    (rst_n),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdc_rise (mdc_rise),
        .mdio_s   (mdio_s)
    );

    mdio_state_e       state_q, state_d;
    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic              is_read_q, is_read_d;
    logic              op_msb_q, op_msb_d;
    logic              ta_ok_q, ta_ok_d;
    logic [15:0]       shift_q, shift_d;
    logic              mdio_o_q, mdio_o_d;
    logic              mdio_oe_q, mdio_oe_d;
    logic [4:0]        reg_addr_q, reg_addr_d;
    logic              reg_re_q, reg_re_d;
    logic              rd_cap_q, rd_cap_d;
    logic              reg_we_q, reg_we_d;
    logic [15:0]       reg_wdata_q, reg_wdata_d;
    logic              frame_err_q, frame_err_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PRE;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            is_read_q   <= 1'b0;
            op_msb_q    <= 1'b0;
            ta_ok_q     <= 1'b0;
            shift_q     <= '0;
            mdio_o_q    <= 1'b0;
            mdio_oe_q   <= 1'b0;
            reg_addr_q  <= '0;
            reg_re_q    <= 1'b0;
            rd_cap_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            is_read_q   <= is_read_d;
            op_msb_q    <= op_msb_d;
            ta_ok_q     <= ta_ok_d;
            shift_q     <= shift_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_re_q    <= reg_re_d;
            rd_cap_q    <= rd_cap_d;
            reg_we_q    <= reg_we_d;
            reg_wdata_q <= reg_wdata_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        is_read_d   = is_read_q;
        op_msb_d    = op_msb_q;
        ta_ok_d     = ta_ok_q;
        shift_d     = shift_q;
        mdio_o_d    = mdio_o_q;
        mdio_oe_d   = mdio_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_re_d    = 1'b0;
        rd_cap_d    = reg_re_q;
        reg_we_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        frame_err_d = 1'b0;

        if (mdc_rise) begin
            unique case (state_q)
                PRE: begin
                    if (mdio_s) begin
                        if (pre_cnt_q != PRE_SAT) pre_cnt_d = pre_cnt_q + 1'b1;
                    end else begin
                        // This zero is the first start bit when the preamble was long enough.
                        if (pre_cnt_q == PRE_SAT) state_d = ST;
                        pre_cnt_d = '0;
                    end
                end
                ST: begin
                    bit_cnt_d = '0;
                    state_d   = mdio_s ? OP : PRE;
                end
                OP: begin
                    if (bit_cnt_q == 5'd0) begin
                        op_msb_d  = mdio_s;
                        bit_cnt_d = 5'd1;
                    end else begin
                        bit_cnt_d = '0;
                        if ({op_msb_q, mdio_s} == OP_READ) begin
                            is_read_d = 1'b1;
                            state_d   = PHYAD;
                        end else if ({op_msb_q, mdio_s} == OP_WRITE) begin
                            is_read_d = 1'b0;
                            state_d   = PHYAD;
                        end else begin
                            state_d = PRE;
                        end
                    end
                end
                PHYAD: begin
                    shift_d = {shift_q[14:0], mdio_s};
                    if (bit_cnt_q == PHYAD_LAST) begin
                        if ({shift_q[PHYAD_W-2:0], mdio_s} == PHY_ADDR) begin
                            bit_cnt_d = '0;
                            state_d   = REGAD;
                        end else begin
                            bit_cnt_d = SKIP_PHY;
                            state_d   = SKIP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                REGAD: begin
                    shift_d = {shift_q[14:0], mdio_s};
                    if (bit_cnt_q == REGAD_LAST) begin
                        reg_addr_d = {shift_q[REGAD_W-2:0], mdio_s};
                        reg_re_d   = is_read_q;
                        bit_cnt_d  = '0;
                        state_d    = TA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                TA: begin
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                        if (is_read_q) begin
                            mdio_oe_d = 1'b1;
                            mdio_o_d  = 1'b0;
                        end else begin
                            ta_ok_d = mdio_s;
                        end
                    end else begin
                        bit_cnt_d = '0;
                        if (is_read_q) begin
                            mdio_o_d = shift_q[15];
                            shift_d  = {shift_q[14:0], 1'b0};
                            state_d  = DATA;
                        end else if (ta_ok_q && !mdio_s) begin
                            state_d = DATA;
                        end else begin
                            frame_err_d = 1'b1;
                            bit_cnt_d   = SKIP_TAE;
                            state_d     = SKIP;
                        end
                    end
                end
                DATA: begin
                    // Reads present the next bit one rise ahead; the final rise releases the pad.
                    if (is_read_q) begin
                        if (bit_cnt_q == DATA_LAST) begin
                            mdio_oe_d = 1'b0;
                            mdio_o_d  = 1'b0;
                        end else begin
                            mdio_o_d = shift_q[15];
                            shift_d  = {shift_q[14:0], 1'b0};
                        end
                    end else begin
                        shift_d = {shift_q[14:0], mdio_s};
                        if (bit_cnt_q == DATA_LAST) begin
                            reg_wdata_d = {shift_q[14:0], mdio_s};
                            reg_we_d    = 1'b1;
                        end
                    end
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = PRE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                SKIP: begin
                    if (bit_cnt_q <= 5'd1) begin
                        bit_cnt_d = '0;
                        state_d   = PRE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
                default: begin
                    bit_cnt_d = '0;
                    pre_cnt_d = '0;
                    state_d   = PRE;
                end
            endcase
        end

        if (rd_cap_q) shift_d = reg_rdata;
    end

    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_re    = reg_re_q;
    assign reg_we    = reg_we_q;
    assign reg_wdata = reg_wdata_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Randomized bench for mdio_responder: an MDIO master drives frames and a
// frame-level model predicts register-port activity and read-back data.
`timescale 1ns/1ps
module tb_mdio_responder;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        mdc;
    logic        m_oe;
    logic        m_val;
    logic        mdio_pad;
    logic        mdio_o;
    logic        mdio_oe;
    logic [4:0]  reg_addr;
    logic        reg_re;
    logic [15:0] reg_rdata;
    logic        reg_we;
    logic [15:0] reg_wdata;
    logic        frame_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #10 clock = ~clock;

    assign mdio_pad = mdio_oe ? mdio_o : (m_oe ? m_val : 1'b1);

    mdio_responder #(.PHY_ADDR(5'd1), .PRE_LEN(32)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .mdc       (mdc),
        .mdio_i    (mdio_pad),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .reg_addr  (reg_addr),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .frame_err (frame_err)
    );

    // Register-port monitor: free-running pulse totals plus the values seen on each write.
    int          we_tot = 0, re_tot = 0, err_tot = 0, oe_tot = 0;
    logic [4:0]  we_addr = '0;
    logic [15:0] we_data = '0;
    logic        re_d = 1'b0;
    logic [15:0] rd_val = '0;

    always @(negedge clock) begin
        re_d = reg_re;
        if (reg_we) begin
            we_tot  = we_tot + 1;
            we_addr = reg_addr;
            we_data = reg_wdata;
        end
        if (reg_re)    re_tot  = re_tot + 1;
        if (frame_err) err_tot = err_tot + 1;
        if (mdio_oe)   oe_tot  = oe_tot + 1;
    end

    // Register file: valid data only in the cycle after reg_re, noise otherwise.
    always @(posedge clock) begin
        #1;
        reg_rdata = re_d ? rd_val : 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int   n_we;
        int   n_re;
        int   n_err;
        logic drives;
    } exp_t;

    // Frame-level outcome from the protocol rules alone.
    function automatic exp_t model(input int pre, input logic [1:0] op,
                                   input logic [4:0] phy, input logic [1:0] ta);
        exp_t e;
        e.n_we = 0; e.n_re = 0; e.n_err = 0; e.drives = 1'b0;
        if (pre >= 32 && phy == 5'd1) begin
            if (op == 2'b10) begin
                e.n_re   = 1;
                e.drives = 1'b1;
            end else if (op == 2'b01) begin
                if (ta == 2'b10) e.n_we = 1;
                else             e.n_err = 1;
            end
        end
        return e;
    endfunction

    task automatic send_bit(input logic b, input logic drive, output logic smp, output logic oe_r);
        mdc   = 1'b0;
        m_oe  = drive;
        m_val = b;
        #100;
        mdc  = 1'b1;
        smp  = mdio_pad;
        oe_r = mdio_oe;
        #100;
    endtask

    task automatic do_frame(input string nm, input int pre, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] ra, input logic [1:0] ta,
                            input logic [15:0] data, input int abort_bit);
        exp_t        e;
        logic        s, o, rd, ta2, last_oe;
        logic [1:0]  ta_oe;
        logic [15:0] got_d;
        int          we0, re0, err0, oe0;
        e  = model(pre, op, phy, ta);
        rd = (op == 2'b10);
        rd_val = data;
        we0 = we_tot; re0 = re_tot; err0 = err_tot; oe0 = oe_tot;
        got_d = '0; ta_oe = '0; ta2 = 1'b0; last_oe = 1'b0;
        for (int i = 0; i < pre; i++) send_bit(1'b1, 1'b1, s, o);
        send_bit(1'b0, 1'b1, s, o);
        send_bit(1'b1, 1'b1, s, o);
        for (int i = 1; i >= 0; i--) send_bit(op[i], 1'b1, s, o);
        for (int i = 4; i >= 0; i--) send_bit(phy[i], 1'b1, s, o);
        for (int i = 4; i >= 0; i--) send_bit(ra[i], 1'b1, s, o);
        send_bit(ta[1], !rd, s, o); ta_oe[1] = o;
        send_bit(ta[0], !rd, s, o); ta_oe[0] = o; ta2 = s;
        for (int i = 15; i >= 0; i--) begin
            if (i == abort_bit) begin
                mdc  = 1'b0;
                m_oe = 1'b0;
                #60;
                chk({nm, ".oe_before_rst"}, 32'(mdio_oe), 32'd1);
                rst_n = 1'b0;
                #1;
                chk({nm, ".oe_async_drop"}, 32'(mdio_oe), 32'd0);
                chk({nm, ".addr_rst"}, 32'(reg_addr), 32'd0);
                chk({nm, ".mdio_o_rst"}, 32'(mdio_o), 32'd0);
                repeat (3) @(negedge clock);
                rst_n = 1'b1;
                repeat (3) @(negedge clock);
                return;
            end
            send_bit(data[i], !rd, s, o);
            got_d[i] = s;
            last_oe  = o;
        end
        #100;
        chk({nm, ".we"}, 32'(we_tot - we0), 32'(e.n_we));
        chk({nm, ".re"}, 32'(re_tot - re0), 32'(e.n_re));
        chk({nm, ".err"}, 32'(err_tot - err0), 32'(e.n_err));
        chk({nm, ".oe_end"}, 32'(mdio_oe), 32'd0);
        if (e.n_we == 1) begin
            chk({nm, ".waddr"}, 32'(we_addr), 32'(ra));
            chk({nm, ".wdata"}, 32'(we_data), 32'(data));
            chk({nm, ".wdata_held"}, 32'(reg_wdata), 32'(data));
        end
        if (e.drives) begin
            chk({nm, ".raddr"}, 32'(reg_addr), 32'(ra));
            chk({nm, ".ta1_oe"}, 32'(ta_oe[1]), 32'd0);
            chk({nm, ".ta2_oe"}, 32'(ta_oe[0]), 32'd1);
            chk({nm, ".ta2_bit"}, 32'(ta2), 32'd0);
            chk({nm, ".rdata"}, 32'(got_d), 32'(data));
            chk({nm, ".d0_oe"}, 32'(last_oe), 32'd1);
        end else begin
            chk({nm, ".no_drive"}, 32'(oe_tot - oe0), 32'd0);
        end
        mdc = 1'b1;
        #300;
    endtask

    initial begin
        logic [1:0]  op, ta;
        logic [4:0]  phy, ra;
        int          pick;
        string       nm;
        rst_n = 1'b0; mdc = 1'b0; m_oe = 1'b1; m_val = 1'b1; reg_rdata = '0;
        repeat (5) @(negedge clock);
        chk("rst.mdio_o", 32'(mdio_o), 32'd0);
        chk("rst.mdio_oe", 32'(mdio_oe), 32'd0);
        chk("rst.reg_addr", 32'(reg_addr), 32'd0);
        chk("rst.reg_re", 32'(reg_re), 32'd0);
        chk("rst.reg_we", 32'(reg_we), 32'd0);
        chk("rst.reg_wdata", 32'(reg_wdata), 32'd0);
        chk("rst.frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clock);

        do_frame("write", 32, 2'b01, 5'd1, 5'd4, 2'b10, 16'hA5C3, -1);
        do_frame("read", 32, 2'b10, 5'd1, 5'd2, 2'b10, 16'h1234, -1);
        do_frame("foreign", 32, 2'b10, 5'd3, 5'd2, 2'b10, 16'hBEEF, -1);
        do_frame("after_foreign", 32, 2'b01, 5'd1, 5'd7, 2'b10, 16'h0F0F, -1);
        do_frame("short_pre", 31, 2'b01, 5'd1, 5'd9, 2'b10, 16'h5555, -1);
        do_frame("long_pre", 40, 2'b01, 5'd1, 5'd9, 2'b10, 16'h6789, -1);
        do_frame("op11", 32, 2'b11, 5'd1, 5'd3, 2'b10, 16'h1111, -1);
        do_frame("ta11", 32, 2'b01, 5'd1, 5'd5, 2'b11, 16'h2222, -1);
        do_frame("rst_mid", 32, 2'b10, 5'd1, 5'd6, 2'b10, 16'hC0DE, 8);
        do_frame("after_rst", 32, 2'b10, 5'd1, 5'd6, 2'b10, 16'h8001, -1);

        for (int k = 0; k < 12; k++) begin
            pick = $urandom_range(0, 9);
            if (pick < 4)      op = 2'b01;
            else if (pick < 8) op = 2'b10;
            else               op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            if ($urandom_range(0, 3) == 0) begin
                phy = 5'($urandom_range(0, 31));
                if (phy == 5'd1) phy = 5'd2;
            end else begin
                phy = 5'd1;
            end
            ta = 2'b10;
            if ($urandom_range(0, 3) == 0) begin
                ta = 2'($urandom_range(0, 3));
                if (ta == 2'b10) ta = 2'b00;
            end
            ra = 5'($urandom_range(0, 31));
            nm = $sformatf("rnd%0d", k);
            do_frame(nm, 32 + $urandom_range(0, 8), op, phy, ra, ta, 16'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
